// File: rtl/pb_debug_bram_mux.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : pb_debug_bram_mux
//  Description : Host-to-PicoBlaze debug access engine. Serialises single-word
//                read/write transactions from one host port onto N program
//                BRAM debug ports, with broadcast write, optional channel
//                order reversal, registered readback and per-core reset
//                stretching.
//  Ports       : jtag_clk/jtag_rst_n  clock, async active-low reset
//                host_*               host transaction port (req/busy/ack)
//                host_rst_req         per-channel core reset request
//                pb_en/we/addr/din    shared BRAM debug write/read bus
//                pb_dout              concatenated BRAM read data
//                pb_rst               per-core stretched reset
//  Revision    : 1.0  initial release
// ============================================================================
module pb_debug_bram_mux #(
    parameter int C_NUM_PICOBLAZE    = 8,
    parameter int BRAM_ADDRESS_WIDTH = 10,
    parameter int DATA_WIDTH         = 18,
    parameter int REVERSE_ORDER      = 1,
    parameter int RST_HOLD_CYCLES    = 4,
    localparam int SEL_W = (C_NUM_PICOBLAZE > 1) ? $clog2(C_NUM_PICOBLAZE) : 1
) (
    input  logic                                  jtag_clk,
    input  logic                                  jtag_rst_n,
    input  logic                                  host_req,
    input  logic                                  host_we,
    input  logic                                  host_bcast,
    input  logic [SEL_W-1:0]                      host_sel,
    input  logic [BRAM_ADDRESS_WIDTH-1:0]         host_addr,
    input  logic [DATA_WIDTH-1:0]                 host_wdata,
    output logic                                  host_busy,
    output logic                                  host_ack,
    output logic                                  host_err,
    output logic [DATA_WIDTH-1:0]                 host_rdata,
    input  logic [C_NUM_PICOBLAZE-1:0]            host_rst_req,
    output logic [C_NUM_PICOBLAZE-1:0]            pb_en,
    output logic                                  pb_we,
    output logic [BRAM_ADDRESS_WIDTH-1:0]         pb_addr,
    output logic [DATA_WIDTH-1:0]                 pb_din,
    input  logic [C_NUM_PICOBLAZE*DATA_WIDTH-1:0] pb_dout,
    output logic [C_NUM_PICOBLAZE-1:0]            pb_rst
);

    localparam int N  = C_NUM_PICOBLAZE;
    localparam int AW = BRAM_ADDRESS_WIDTH;
    localparam int DW = DATA_WIDTH;

    localparam logic [SEL_W-1:0] C_LAST_SEL  = SEL_W'(N - 1);
    localparam logic [N-1:0]     C_ONE       = N'(1);
    localparam logic [7:0]       C_HOLD_LOAD = 8'(RST_HOLD_CYCLES);

    localparam logic [1:0] C_ST_IDLE  = 2'd0;
    localparam logic [1:0] C_ST_ISSUE = 2'd1;
    localparam logic [1:0] C_ST_WAIT  = 2'd2;
    localparam logic [1:0] C_ST_RESP  = 2'd3;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;

    // Transaction fields latched on acceptance so the host may change its
    // inputs while the transaction is in flight.
    logic             r_we;
    logic             r_bcast;
    logic [SEL_W-1:0] r_sel;
    logic [AW-1:0]    r_addr;
    logic [DW-1:0]    r_wdata;

    logic             w_illegal;
    logic [SEL_W-1:0] w_phys;
    logic [DW-1:0]    w_slice;

    logic             w_busy_nxt;
    logic             w_ack_nxt;
    logic             w_err_nxt;
    logic [DW-1:0]    w_rdata_nxt;
    logic [N-1:0]     w_en_nxt;
    logic             w_we_nxt;
    logic [AW-1:0]    w_addr_nxt;
    logic [DW-1:0]    w_din_nxt;

    // A select beyond the last core, or a broadcast read, is rejected: the
    // FSM still walks ISSUE/RESP but no port is ever enabled.
    assign w_illegal = (r_sel > C_LAST_SEL) || (r_bcast && !r_we);
    assign w_phys    = (REVERSE_ORDER != 0) ? (C_LAST_SEL - r_sel) : r_sel;

    always_comb begin
        w_slice = '0;
        for (int p = 0; p < N; p++) begin
            if (w_phys == SEL_W'(p)) begin
                w_slice = pb_dout[p*DW +: DW];
            end
        end
    end

    // State register and registered outputs
    always_ff @(posedge jtag_clk or negedge jtag_rst_n) begin
        if (!jtag_rst_n) begin
            r_state    <= C_ST_IDLE;
            r_we       <= 1'b0;
            r_bcast    <= 1'b0;
            r_sel      <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            host_busy  <= 1'b0;
            host_ack   <= 1'b0;
            host_err   <= 1'b0;
            host_rdata <= '0;
            pb_en      <= '0;
            pb_we      <= 1'b0;
            pb_addr    <= '0;
            pb_din     <= '0;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == C_ST_IDLE) && host_req) begin
                r_we    <= host_we;
                r_bcast <= host_bcast;
                r_sel   <= host_sel;
                r_addr  <= host_addr;
                r_wdata <= host_wdata;
            end
            host_busy  <= w_busy_nxt;
            host_ack   <= w_ack_nxt;
            host_err   <= w_err_nxt;
            host_rdata <= w_rdata_nxt;
            pb_en      <= w_en_nxt;
            pb_we      <= w_we_nxt;
            pb_addr    <= w_addr_nxt;
            pb_din     <= w_din_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            C_ST_IDLE:  if (host_req) w_state_nxt = C_ST_ISSUE;
            // Only a legal read needs the extra cycle for BRAM read latency.
            C_ST_ISSUE: w_state_nxt = (r_we || w_illegal) ? C_ST_RESP : C_ST_WAIT;
            C_ST_WAIT:  w_state_nxt = C_ST_RESP;
            C_ST_RESP:  w_state_nxt = C_ST_IDLE;
            default:    w_state_nxt = C_ST_IDLE;
        endcase
    end

    // Output logic: values loaded into the output registers at the next edge
    always_comb begin
        w_busy_nxt  = host_busy;
        w_ack_nxt   = 1'b0;
        w_err_nxt   = 1'b0;
        w_rdata_nxt = host_rdata;
        w_en_nxt    = '0;
        w_we_nxt    = 1'b0;
        w_addr_nxt  = pb_addr;
        w_din_nxt   = pb_din;
        case (r_state)
            C_ST_IDLE: begin
                if (host_req) w_busy_nxt = 1'b1;
            end
            C_ST_ISSUE: begin
                w_addr_nxt = r_addr;
                w_din_nxt  = r_wdata;
                w_we_nxt   = r_we && !w_illegal;
                if (!w_illegal) begin
                    w_en_nxt = r_bcast ? '1 : (C_ONE << w_phys);
                end
            end
            C_ST_RESP: begin
                w_busy_nxt  = 1'b0;
                w_ack_nxt   = 1'b1;
                w_err_nxt   = w_illegal;
                w_rdata_nxt = w_illegal ? '0 : w_slice;
            end
            default: begin
            end
        endcase
    end

    // Per-core reset stretching, fully independent of the access FSM
    logic [N-1:0] w_rst_req_phys;
    logic [7:0]   r_hold_cnt [N];

    for (genvar p = 0; p < N; p++) begin : g_rst_map
        localparam int C_CH = (REVERSE_ORDER != 0) ? (N - 1 - p) : p;
        assign w_rst_req_phys[p] = host_rst_req[C_CH];
    end

    always_ff @(posedge jtag_clk or negedge jtag_rst_n) begin
        if (!jtag_rst_n) begin
            for (int p = 0; p < N; p++) begin
                r_hold_cnt[p] <= C_HOLD_LOAD;
            end
            pb_rst <= '1;
        end else begin
            for (int p = 0; p < N; p++) begin
                if (w_rst_req_phys[p]) begin
                    r_hold_cnt[p] <= C_HOLD_LOAD;
                    pb_rst[p]     <= 1'b1;
                end else if (r_hold_cnt[p] != 8'd0) begin
                    r_hold_cnt[p] <= r_hold_cnt[p] - 8'd1;
                    pb_rst[p]     <= 1'b1;
                end else begin
                    pb_rst[p]     <= 1'b0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pb_debug_bram_mux.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_pb_debug_bram_mux
//  Description : Self-checking bench for pb_debug_bram_mux (5 cores, reversed
//                channel order) with a BRAM model on the debug ports and a
//                transaction-level reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pb_debug_bram_mux;

    localparam int N    = 5;
    localparam int AW   = 10;
    localparam int DW   = 18;
    localparam int HOLD = 4;
    localparam int SW   = 3;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            host_req = 1'b0;
    logic            host_we = 1'b0;
    logic            host_bcast = 1'b0;
    logic [SW-1:0]   host_sel = '0;
    logic [AW-1:0]   host_addr = '0;
    logic [DW-1:0]   host_wdata = '0;
    logic            host_busy;
    logic            host_ack;
    logic            host_err;
    logic [DW-1:0]   host_rdata;
    logic [N-1:0]    host_rst_req = '0;
    logic [N-1:0]    pb_en;
    logic            pb_we;
    logic [AW-1:0]   pb_addr;
    logic [DW-1:0]   pb_din;
    logic [N*DW-1:0] pb_dout;
    logic [N-1:0]    pb_rst;

    always #5 clk = ~clk;

    pb_debug_bram_mux #(
        .C_NUM_PICOBLAZE   (N),
        .BRAM_ADDRESS_WIDTH(AW),
        .DATA_WIDTH        (DW),
        .REVERSE_ORDER     (1),
        .RST_HOLD_CYCLES   (HOLD)
    ) u_dut (
        .jtag_clk    (clk),
        .jtag_rst_n  (rst_n),
        .host_req    (host_req),
        .host_we     (host_we),
        .host_bcast  (host_bcast),
        .host_sel    (host_sel),
        .host_addr   (host_addr),
        .host_wdata  (host_wdata),
        .host_busy   (host_busy),
        .host_ack    (host_ack),
        .host_err    (host_err),
        .host_rdata  (host_rdata),
        .host_rst_req(host_rst_req),
        .pb_en       (pb_en),
        .pb_we       (pb_we),
        .pb_addr     (pb_addr),
        .pb_din      (pb_din),
        .pb_dout     (pb_dout),
        .pb_rst      (pb_rst)
    );

    function automatic logic [DW-1:0] init_word(input int key);
        return DW'(key * 2749 + 12345);
    endfunction

    // BRAM model: one memory per physical port, 1-cycle read latency
    logic [DW-1:0] bram [N*1024];
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N*1024; i++) bram[i] <= init_word(i);
            pb_dout <= '0;
        end else begin
            for (int p = 0; p < N; p++) begin
                if (pb_en[p]) begin
                    if (pb_we) bram[p*1024 + int'(pb_addr)] <= pb_din;
                    else pb_dout[p*DW +: DW] <= bram[p*1024 + int'(pb_addr)];
                end
            end
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state (transaction level)
    int            edge_k;
    bit            m_busy;
    int            t0, lat;
    bit            m_we, m_illegal;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_rdata;
    logic [N-1:0]  m_mask;
    int            rst_last [N];
    logic [DW-1:0] exp_wr [int];

    function automatic logic [N-1:0] exp_rst_vec();
        logic [N-1:0] v;
        for (int p = 0; p < N; p++) v[p] = ((edge_k - rst_last[p]) <= HOLD);
        return v;
    endfunction

    task automatic model_reset();
        edge_k = 0;
        m_busy = 1'b0;
        for (int p = 0; p < N; p++) rst_last[p] = 0;
        exp_wr.delete();
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_busy"},  host_busy,  0);
        chk({tag, "_ack"},   host_ack,   0);
        chk({tag, "_err"},   host_err,   0);
        chk({tag, "_rdata"}, host_rdata, 0);
        chk({tag, "_pb_en"}, pb_en,      0);
        chk({tag, "_pb_we"}, pb_we,      0);
        chk({tag, "_addr"},  pb_addr,    0);
        chk({tag, "_din"},   pb_din,     0);
        chk({tag, "_pbrst"}, pb_rst,     {N{1'b1}});
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        host_req = 1'b0;
        host_rst_req = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        chk_reset_values("rst");
    endtask

    // One clock edge: inputs set before the edge are what the DUT samples
    task automatic step();
        bit            s_req, s_we, s_bc;
        int            s_sel, phys, key;
        logic [AW-1:0] s_addr;
        logic [DW-1:0] s_wdata;
        logic [N-1:0]  s_rst, exp_en;
        bit            exp_ack, at_issue;
        s_req = host_req; s_we = host_we; s_bc = host_bcast; s_sel = int'(host_sel);
        s_addr = host_addr; s_wdata = host_wdata; s_rst = host_rst_req;
        @(posedge clk);
        #1;
        edge_k++;
        exp_ack = 1'b0;
        if (m_busy) begin
            if (edge_k == t0 + lat) begin
                exp_ack = 1'b1;
                m_busy  = 1'b0;
            end
        end else if (s_req) begin
            m_busy    = 1'b1;
            t0        = edge_k;
            m_we      = s_we;
            m_addr    = s_addr;
            m_wdata   = s_wdata;
            m_illegal = (s_sel >= N) || (s_bc && !s_we);
            lat       = (s_we || m_illegal) ? 2 : 3;
            phys      = N - 1 - s_sel;
            m_mask    = '0;
            m_rdata   = '0;
            if (!m_illegal) begin
                for (int p = 0; p < N; p++) if (s_bc || p == phys) m_mask[p] = 1'b1;
                if (s_we) begin
                    for (int p = 0; p < N; p++) if (m_mask[p]) exp_wr[p*1024 + int'(s_addr)] = s_wdata;
                end else begin
                    key = phys*1024 + int'(s_addr);
                    m_rdata = exp_wr.exists(key) ? exp_wr[key] : init_word(key);
                end
            end
        end
        for (int p = 0; p < N; p++) if (s_rst[N-1-p]) rst_last[p] = edge_k;

        at_issue = m_busy && (edge_k == t0 + 1);
        exp_en   = at_issue ? m_mask : '0;
        chk("busy",   host_busy, m_busy);
        chk("ack",    host_ack,  exp_ack);
        chk("pb_en",  pb_en,     exp_en);
        chk("pb_rst", pb_rst,    exp_rst_vec());
        if (exp_ack) begin
            chk("err", host_err, m_illegal);
            if (m_illegal || !m_we) chk("rdata", host_rdata, m_rdata);
        end
        if (at_issue && !m_illegal) begin
            chk("pb_we",   pb_we,   m_we);
            chk("pb_addr", pb_addr, m_addr);
            chk("pb_din",  pb_din,  m_wdata);
        end else if (!at_issue) begin
            chk("pb_we_idle", pb_we, 0);
        end
    endtask

    task automatic txn(input bit we, input bit bc, input int sel, input int addr,
                       input int data, input bit hold_req);
        host_req   = 1'b1;
        host_we    = we;
        host_bcast = bc;
        host_sel   = SW'(sel);
        host_addr  = AW'(addr);
        host_wdata = DW'(data);
        step();
        if (!hold_req) host_req = 1'b0;
        for (int i = 0; i < 8 && m_busy; i++) step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset release: pb_rst stretched, no ack
        do_reset();
        repeat (7) step();

        // Directed transactions
        txn(1, 0, 2, 'h155, 'h2ABCD, 0);   // write host ch 2 -> port 2
        txn(0, 0, 2, 'h155, 0, 0);         // read it back
        txn(0, 0, 0, 'h010, 0, 0);         // read ch 0 -> port 4 (initial contents)
        txn(1, 0, 0, 'h010, 'h12345, 0);
        txn(0, 0, 0, 'h010, 0, 0);
        txn(1, 1, 1, 'h3FF, 'h3C3C3, 0);   // broadcast write
        txn(0, 0, 3, 'h3FF, 0, 0);
        txn(0, 1, 1, 'h3FF, 0, 0);         // broadcast read -> err
        txn(1, 0, 6, 'h001, 'h11111, 0);   // illegal select write
        txn(0, 0, 5, 'h001, 0, 0);         // illegal select read
        txn(0, 0, 4, 'h3FF, 0, 1);         // request held through busy
        step();                            // held request accepted after ack
        host_req = 1'b0;
        for (int i = 0; i < 8 && m_busy; i++) step();

        // Reset request stretch and reload
        host_rst_req = 5'b00101;
        repeat (3) step();
        host_rst_req = 5'b00001;
        repeat (2) step();
        host_rst_req = 5'b00100;
        repeat (2) step();
        host_rst_req = '0;
        repeat (8) step();

        // Randomised traffic
        for (int c = 0; c < 1500; c++) begin
            host_req   = ($urandom_range(0, 9) < 6);
            host_we    = 1'($urandom_range(0, 1));
            host_bcast = ($urandom_range(0, 7) == 0);
            host_sel   = ($urandom_range(0, 9) < 8) ? SW'($urandom_range(0, N-1))
                                                    : SW'($urandom_range(N, 7));
            host_addr  = ($urandom_range(0, 9) < 8) ? AW'($urandom_range(0, 7)) : AW'('h3FF);
            host_wdata = DW'($urandom);
            if ($urandom_range(0, 9) == 0) host_rst_req[$urandom_range(0, N-1)] ^= 1'b1;
            step();
        end
        host_req = 1'b0;
        host_rst_req = '0;
        for (int i = 0; i < 8 && m_busy; i++) step();

        // Asynchronous reset while a read sits in WAIT
        host_req = 1'b1; host_we = 1'b0; host_bcast = 1'b0; host_sel = 3'd1; host_addr = 10'd3;
        step();
        host_req = 1'b0;
        step();
        #3;
        rst_n = 1'b0;
        #1;
        chk_reset_values("async");
        do_reset();
        repeat (8) step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
